// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam int NUM_PORTS = 2;

   // A byte address is rejected when it is not word aligned or when any bit
   // above the word index is set (beyond the end of the memory).
   function automatic logic addr_bad(input logic [31:0] addr, input int r);
      logic [31:0] hi;
      hi = addr >> (r + 2);
      return (addr[1:0] != 2'b00) || (hi != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-input round-robin picker. The mask restricts eligibility (used to pin
// the grant to the lock owner); last_grant remembers who transferred last.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic [1:0] mask,
   input  logic       advance,
   output logic [1:0] grant
);

   logic [1:0] elig;
   logic       last_grant;

   assign elig = valid & mask;

   // Single eligible port wins outright; on a conflict the port that did not
   // go last wins.
   always_comb begin
      grant = 2'b00;
      case (elig)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Reset to port 1 so that port 0 wins the first conflict.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (advance) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing a single-port word memory between the CPU data port (0)
// and the DMA/debug loader (1), with bounded burst locking.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  ARB    | normal round-robin between both ports
//  LOCKED | only the owner is eligible; lock_cnt counts its grants so far
module dmem_arbiter #(
   parameter int n        = 16,
   parameter int r        = 6,
   parameter int LOCK_MAX = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [1:0]   req_we,
   input  logic [1:0]   req_lock,
   input  logic [n-1:0] req_addr0,
   input  logic [n-1:0] req_addr1,
   input  logic [n-1:0] req_wdata0,
   input  logic [n-1:0] req_wdata1,
   output logic [1:0]   rsp_valid,
   output logic         rsp_err,
   output logic [n-1:0] rsp_rdata,
   output logic         mem_we,
   output logic [n-1:0] mem_addr,
   output logic [n-1:0] mem_wdata,
   input  logic [n-1:0] mem_rdata
);

   import dmem_arb_pkg::*;

   localparam int CW = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   arb_state_t    state, state_nx;
   logic          owner, owner_nx;
   logic [CW-1:0] lock_cnt, cnt_nx;

   logic          other;
   logic          owner_v, other_v;
   logic          forced;
   logic          hold;
   logic [1:0]    mask;
   logic [1:0]    grant;
   logic          xfer;
   logic          sel;
   logic          err0, err1;
   logic          sel_err, sel_we;
   logic [n-1:0]  sel_addr, sel_wdata;

   // The lock only pins the grant while the owner is still asking and no
   // forced release is due; otherwise this cycle arbitrates as in ARB, and
   // since the owner went last the other port wins any conflict.
   always_comb begin
      other   = ~owner;
      owner_v = req_valid[owner];
      other_v = req_valid[other];
      forced  = (lock_cnt == CNT_MAX) && other_v;
      hold    = (state == LOCKED) && owner_v && !forced;
      mask    = 2'b11;
      if (hold) begin
         mask = owner ? 2'b10 : 2'b01;
      end
   end

   rr_arbiter2 u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (req_valid),
      .mask    (mask),
      .advance (xfer),
      .grant   (grant)
   );

   assign req_ready = grant & {2{rst_n}};
   assign xfer      = |req_ready;
   assign sel       = req_ready[1];

   assign err0 = addr_bad(32'(req_addr0), r);
   assign err1 = addr_bad(32'(req_addr1), r);

   // Steer the granted port onto the memory; an idle bus drives zeros.
   always_comb begin
      sel_err   = sel ? err1 : err0;
      sel_we    = sel ? req_we[1] : req_we[0];
      sel_addr  = sel ? req_addr1 : req_addr0;
      sel_wdata = sel ? req_wdata1 : req_wdata0;
      mem_we    = xfer && sel_we && !sel_err;
      mem_addr  = xfer ? sel_addr : '0;
      mem_wdata = xfer ? sel_wdata : '0;
   end

   // Lock state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ARB;
         owner    <= 1'b0;
         lock_cnt <= '0;
      end else begin
         state    <= state_nx;
         owner    <= owner_nx;
         lock_cnt <= cnt_nx;
      end
   end

   // Lock next-state: count owner beats (saturating), release on a beat
   // without lock, and (re)enter the lock from any arbitrated transfer.
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      cnt_nx   = lock_cnt;
      if (hold) begin
         if (xfer) begin
            if (req_lock[owner]) begin
               if (lock_cnt != CNT_MAX) begin
                  cnt_nx = lock_cnt + CNT_ONE;
               end
            end else begin
               state_nx = ARB;
               cnt_nx   = '0;
            end
         end
      end else begin
         state_nx = ARB;
         cnt_nx   = '0;
         if (xfer && req_lock[sel]) begin
            state_nx = LOCKED;
            owner_nx = sel;
            cnt_nx   = CNT_ONE;
         end
      end
   end

   // One-cycle registered response; read data only for clean reads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 2'b00;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= req_ready;
         rsp_err   <= xfer && sel_err;
         rsp_rdata <= (xfer && !sel_we && !sel_err) ? mem_rdata : '0;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of grants, lock and memory.
module tb_dmem_arbiter;

   localparam int N     = 16;
   localparam int R     = 6;
   localparam int LM    = 8;
   localparam int WORDS = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid, req_ready, req_we, req_lock;
   logic [N-1:0]  req_addr0, req_addr1, req_wdata0, req_wdata1;
   logic [1:0]    rsp_valid;
   logic          rsp_err;
   logic [N-1:0]  rsp_rdata;
   logic          mem_we;
   logic [N-1:0]  mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dmem_arbiter #(.n(N), .r(R), .LOCK_MAX(LM)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_lock   (req_lock),
      .req_addr0  (req_addr0),
      .req_addr1  (req_addr1),
      .req_wdata0 (req_wdata0),
      .req_wdata1 (req_wdata1),
      .rsp_valid  (rsp_valid),
      .rsp_err    (rsp_err),
      .rsp_rdata  (rsp_rdata),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   function automatic logic [N-1:0] init_word(input int i);
      return 16'(i * 16'h0B17 + 16'h3C5A);
   endfunction

   // Memory attached to the DUT.
   logic         preload;
   logic [N-1:0] tb_mem [WORDS];
   assign mem_rdata = tb_mem[mem_addr[R+1:2]];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < WORDS; i++) tb_mem[i] <= init_word(i);
      end else if (mem_we) begin
         tb_mem[mem_addr[R+1:2]] <= mem_wdata;
      end
   end

   // Reference model state.
   logic [N-1:0] ref_mem [WORDS];
   int           m_last, m_owner, m_beats;
   logic [1:0]   p_rv;
   logic         p_err;
   logic [N-1:0] p_rd;

   // Requested stimulus for the next cycle.
   logic         d_rst;
   logic [1:0]   d_valid, d_we, d_lock;
   logic [N-1:0] d_addr [2];
   logic [N-1:0] d_wdata [2];

   logic [1:0]   obs_ready;
   logic         obs_we;
   logic [N-1:0] obs_addr;

   int n_asserts = 0;
   int n_fail    = 0;
   int burst [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic bad_addr(input logic [N-1:0] a);
      return (a % 4 != 0) || (int'(a) >= 4 * WORDS);
   endfunction

   // One clock: drive at the falling edge, check combinational outputs,
   // advance the model, then check the response just after the rising edge.
   task automatic step();
      int         g;
      int         held;
      logic       e;
      logic [1:0] exp_ready;
      logic [N-1:0] a;
      @(negedge clk);
      rst_n      = d_rst;
      req_valid  = d_valid;
      req_we     = d_we;
      req_lock   = d_lock;
      req_addr0  = d_addr[0];
      req_addr1  = d_addr[1];
      req_wdata0 = d_wdata[0];
      req_wdata1 = d_wdata[1];
      #1;
      g    = -1;
      held = 0;
      if (d_rst) begin
         held = (m_owner >= 0) && d_valid[m_owner] &&
                !(m_beats >= LM && d_valid[1 - m_owner]);
         if (held != 0)             g = m_owner;
         else if (d_valid == 2'b11) g = 1 - m_last;
         else if (d_valid[0])       g = 0;
         else if (d_valid[1])       g = 1;
      end
      exp_ready = 2'b00;
      e = 1'b0;
      a = '0;
      if (g >= 0) begin
         exp_ready[g] = 1'b1;
         a = d_addr[g];
         e = bad_addr(a);
      end
      obs_ready = req_ready;
      obs_we    = mem_we;
      obs_addr  = mem_addr;
      chk("req_ready", req_ready, exp_ready);
      chk("mem_we", mem_we, (g >= 0) && d_we[g] && !e);
      chk("mem_addr", mem_addr, a);
      if (g >= 0 && d_we[g] && !e) chk("mem_wdata", mem_wdata, d_wdata[g]);

      if (!d_rst) begin
         m_last = 1; m_owner = -1; m_beats = 0;
         p_rv = 2'b00; p_err = 1'b0; p_rd = '0;
      end else begin
         p_rv = exp_ready; p_err = 1'b0; p_rd = '0;
         if (g >= 0) begin
            p_err = e;
            if (!d_we[g] && !e) p_rd = ref_mem[a / 4];
            if (d_we[g] && !e) ref_mem[a / 4] = d_wdata[g];
            m_last = g;
            if (held != 0) begin
               if (d_lock[g]) begin
                  if (m_beats < LM) m_beats++;
               end else begin
                  m_owner = -1; m_beats = 0;
               end
            end else begin
               m_owner = -1; m_beats = 0;
               if (d_lock[g]) begin m_owner = g; m_beats = 1; end
            end
         end else begin
            m_owner = -1; m_beats = 0;
         end
      end

      @(posedge clk);
      #1;
      chk("rsp_valid", rsp_valid, p_rv);
      if (p_rv != 2'b00 || !d_rst) begin
         chk("rsp_err", rsp_err, p_err);
         chk("rsp_rdata", rsp_rdata, p_rd);
      end
   endtask

   task automatic put(input int p, input logic we, input logic lk,
                      input logic [N-1:0] a, input logic [N-1:0] d);
      d_valid[p] = 1'b1; d_we[p] = we; d_lock[p] = lk;
      d_addr[p] = a; d_wdata[p] = d;
   endtask

   task automatic idle();
      d_valid = 2'b00; d_we = 2'b00; d_lock = 2'b00;
   endtask

   task automatic rand_req(input int p);
      if (burst[p] == 0 && $urandom_range(0, 7) == 0) burst[p] = $urandom_range(3, 14);
      d_valid[p] = 1'b1;
      d_we[p]    = 1'($urandom_range(0, 1));
      d_lock[p]  = (burst[p] > 0);
      if ($urandom_range(0, 7) == 0) d_addr[p] = 16'($urandom);
      else                           d_addr[p] = 16'($urandom_range(0, WORDS - 1) * 4);
      d_wdata[p] = 16'($urandom);
   endtask

   initial begin
      logic [N-1:0] old;
      for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
      m_last = 1; m_owner = -1; m_beats = 0;
      p_rv = 2'b00; p_err = 1'b0; p_rd = '0;
      burst[0] = 0; burst[1] = 0;
      d_addr[0] = '0; d_addr[1] = '0; d_wdata[0] = '0; d_wdata[1] = '0;
      idle();

      // Reset with memory preload.
      preload = 1'b1;
      d_rst = 1'b0;
      step();
      preload = 1'b0;
      step();
      chk("reset_rsp_valid", rsp_valid, 2'b00);

      // Single write then read back.
      d_rst = 1'b1;
      put(0, 1'b1, 1'b0, 16'h0008, 16'h1234);
      step();
      chk("wr_mem_we", obs_we, 1'b1);
      chk("wr_mem_addr", obs_addr, 16'h0008);
      chk("wr_rsp_valid", rsp_valid, 2'b01);
      chk("wr_rsp_err", rsp_err, 1'b0);
      put(0, 1'b0, 1'b0, 16'h0008, 16'h0000);
      step();
      chk("rd_back", rsp_rdata, 16'h1234);
      idle();
      step();

      // Contention from reset: strict alternation, no idle cycles.
      d_rst = 1'b0;
      step();
      d_rst = 1'b1;
      put(0, 1'b0, 1'b0, 16'h0010, 16'h0);
      put(1, 1'b0, 1'b0, 16'h0014, 16'h0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("alt_grant", obs_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk("alt_rsp", rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      idle();
      step();

      // Lock bound: 8 port-1 grants, then port 0.
      put(1, 1'b1, 1'b1, 16'h0020, 16'hA001);
      step();
      chk("lock_first", obs_ready, 2'b10);
      put(0, 1'b0, 1'b0, 16'h0024, 16'h0);
      for (int i = 0; i < 8; i++) begin
         d_wdata[1] = 16'(16'hA002 + i);
         step();
         chk("lock_seq", obs_ready, (i < 7) ? 2'b10 : 2'b01);
      end
      d_valid[0] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("lock_alone", obs_ready, 2'b10);
      end
      idle();
      step();

      // Error responses.
      old = ref_mem[1];
      put(0, 1'b1, 1'b0, 16'h0006, 16'hBEEF);
      step();
      chk("mis_we", obs_we, 1'b0);
      chk("mis_err", rsp_err, 1'b1);
      put(0, 1'b0, 1'b0, 16'h0004, 16'h0);
      step();
      chk("mis_old", rsp_rdata, old);
      put(0, 1'b1, 1'b0, 16'h0100, 16'h5555);
      step();
      chk("oor_err", rsp_err, 1'b1);
      chk("oor_rdata", rsp_rdata, 16'h0000);
      idle();
      step();

      // Reset in the middle of a locked burst.
      put(0, 1'b0, 1'b1, 16'h0030, 16'h0);
      step();
      step();
      d_rst = 1'b0;
      step();
      chk("rst_mid_rsp", rsp_valid, 2'b00);
      d_rst = 1'b1;
      put(0, 1'b0, 1'b0, 16'h0030, 16'h0);
      put(1, 1'b0, 1'b0, 16'h0034, 16'h0);
      step();
      chk("post_rst_p0", obs_ready, 2'b01);
      step();
      chk("post_rst_p1", obs_ready, 2'b10);
      idle();
      step();

      // Lock released by a beat without lock.
      put(1, 1'b0, 1'b0, 16'h0038, 16'h0);
      step();
      put(0, 1'b1, 1'b1, 16'h0040, 16'h1111);
      put(1, 1'b0, 1'b0, 16'h0044, 16'h0);
      step();
      chk("rel_b1", obs_ready, 2'b01);
      d_wdata[0] = 16'h2222;
      step();
      chk("rel_b2", obs_ready, 2'b01);
      d_wdata[0] = 16'h3333;
      d_lock[0]  = 1'b0;
      step();
      chk("rel_b3", obs_ready, 2'b01);
      d_valid[0] = 1'b0;
      step();
      chk("rel_p1", obs_ready, 2'b10);
      idle();
      step();

      // Random traffic; requests stay stable until accepted.
      for (int k = 0; k < 1500; k++) begin
         d_rst = (k % 300 != 299);
         step();
         for (int p = 0; p < 2; p++) begin
            if (obs_ready[p]) begin
               if (burst[p] > 0) burst[p]--;
               if ($urandom_range(0, 3) != 0) rand_req(p);
               else begin d_valid[p] = 1'b0; d_lock[p] = 1'b0; end
            end else if (!d_valid[p] && $urandom_range(0, 1) == 0) begin
               rand_req(p);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port, word-addressed data memory between the CPU data port (port 0) and a DMA/debug loader (port 1).
- Performs at most one memory access per cycle and returns a registered response one cycle later.
- Arbitration is round-robin, with an optional bounded lock for bursts.
- Range and alignment are checked before any write reaches memory.

Parameters:
- n, 16: data/address width in bits, matching the memory.
- r, 6: memory word-index width; the memory holds 2**r words.
- LOCK_MAX, 8: maximum consecutive grants a locking requester may hold while the other port waits; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  2  per-port request valid; bit i is port i.
- req_ready  out  2  per-port accept; combinational, one-hot or zero.
- req_we  in  2  per-port write enable.
- req_lock  in  2  per-port burst-lock request.
- req_addr0, req_addr1  in  n  byte addresses.
- req_wdata0, req_wdata1  in  n  write data.
- rsp_valid  out  2  per-port response pulse.
- rsp_err  out  1  response error flag; qualified by rsp_valid.
- rsp_rdata  out  n  read data; qualified by rsp_valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  n  memory byte address.
- mem_wdata  out  n  memory write data.
- mem_rdata  in  n  memory read data, combinational from mem_addr.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - state=ARB, last_grant=1 (port 0 wins the first conflict), lock_cnt=0.
  - mem_we=0 while rst_n=0.
  - req_ready=0 while rst_n=0.
- Handshake: a transfer occurs on port i when req_valid[i] && req_ready[i] at a rising edge.
  - A requester holds its request fields stable until the transfer.
  - At most one bit of req_ready is set per cycle.
- Grant selection, state ARB:
  - One port valid: that port is granted.
  - Both ports valid: the port != last_grant is granted.
  - last_grant updates to the granted port on every transfer.
- Memory drive (combinational from the granted port):
  - mem_addr = granted port's address; mem_wdata = granted port's data.
  - mem_we = req_we && !err.
  - With no grant: mem_we=0, mem_addr=0.
- err: asserted when addr[1:0]!=0 (misaligned) or addr[n-1:r+2]!=0 (out of range).
  - An erroring request is still accepted; memory is not written.
- Response latency: exactly 1 cycle after a transfer on port i:
  - rsp_valid[i]=1 for one cycle.
  - rsp_err = registered err.
  - rsp_rdata = mem_rdata captured at the transfer edge for an error-free read, else 0.
  - Writes also produce a response, which acts as the write acknowledge.
  - Back-to-back transfers give back-to-back responses. Responses have no backpressure.
- State machine:
  - ARB -> LOCKED(owner=g) on a transfer from port g with req_lock[g]=1; lock_cnt is set to 1.
  - In LOCKED, only the owner is eligible. Each owner transfer increments lock_cnt.
  - LOCKED -> ARB when any of these holds:
    - the owner transfers with req_lock=0;
    - the owner deasserts req_valid;
    - lock_cnt==LOCK_MAX and the other port is valid (forced release).
  - After a forced release, the next grant goes to the other port. If the other port is idle, lock_cnt saturates at LOCK_MAX and the lock persists.
- Boundaries:
  - Reset mid-burst clears the lock, and any response due on the next cycle is suppressed.
  - Simultaneous lock requests are resolved by round-robin first.
  - Both ports idle: no memory write, no responses.

Decomposition:
- Package dmem_arb_pkg: arb_state_t enum {ARB, LOCKED}, NUM_PORTS=2, and an alignment/range check function.
- One natural sub-module, rr_arbiter2: 2-input round-robin picker with a last_grant register and a mask input for lock.

Test Plan:
- Reset/single access:
  - Reset, then port 0 writes 0x1234 to address 0x0008 -> mem_we=1, mem_addr=0x0008 that cycle; next cycle rsp_valid=2'b01, rsp_err=0.
  - Port 0 then reads 0x0008 -> one cycle later rsp_rdata=0x1234.
- Contention:
  - Both ports request reads continuously from reset -> grants alternate 0,1,0,1.
  - rsp_valid alternates 01,10 every cycle, with no idle cycles.
- Lock bound (LOCK_MAX=8):
  - Port 1 holds req_lock=1 with continuous writes while port 0 is valid -> exactly 8 consecutive port 1 grants, then port 0 is granted.
  - With port 0 idle, port 1 is granted indefinitely.
- Errors:
  - Write to 0x0006 -> rsp_err=1, mem_we=0, and a later read of 0x0004 returns its old value.
  - Write to 0x0100 (out of range with r=6) -> rsp_err=1, rsp_rdata=0.
- Reset mid-operation:
  - rst_n=0 during a locked burst, in the cycle after a transfer -> no rsp_valid the next cycle, state=ARB.
  - First post-reset conflict is granted to port 0.
- Lock release:
  - Port 0 locks, issues 3 beats, the third with req_lock=0, while port 1 waits -> port 1 is granted on the 4th cycle.
